// File: rtl/cla4_nibble_sequencer.sv
// ============================================================================
// Module   : cla4_nibble_sequencer
// Brief    : Feeds a WIDTH-bit add through an external 4-bit CLA one nibble per
//            cycle, LSB first, and returns sum, carry-out and signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla4_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_sum,
    input  logic             cla_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_run;
    logic             w_done;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;

    assign w_run  = (r_state == S_RUN);
    assign w_done = (r_state == S_DONE);

    // Nibble select written as a mux over constant slices to keep every bit used.
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int n = 0; n < NIB; n++) begin
            if (r_idx == IW'(n)) begin
                w_a_nib = r_a[4*n +: 4];
                w_b_nib = r_b[4*n +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (r_idx == IW'(n)) begin
                            r_sum[4*n +: 4] <= cla_sum;
                        end
                    end
                    r_carry <= cla_cout;
                    if (r_idx == c_IDX_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Adder inputs are held at zero outside RUN so the CLA stage sees no toggling.
    assign in_ready  = (r_state == S_IDLE);
    assign cla_a     = w_run ? w_a_nib : 4'd0;
    assign cla_b     = w_run ? w_b_nib : 4'd0;
    assign cla_cin   = w_run ? r_carry : 1'b0;

    assign out_valid = w_done;
    assign out_sum   = w_done ? r_sum : '0;
    assign out_cout  = w_done ? r_carry : 1'b0;
    assign out_ovf   = w_done && (r_a[WIDTH-1] == r_b[WIDTH-1])
                              && (r_sum[WIDTH-1] != r_a[WIDTH-1]);

endmodule

`default_nettype wire

// File: tb/tb_cla4_nibble_sequencer.sv
// ============================================================================
// Module   : tb_cla4_nibble_sequencer
// Brief    : Randomized self-checking bench with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla4_nibble_sequencer;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic [3:0]   cla_a;
    logic [3:0]   cla_b;
    logic         cla_cin;
    logic [3:0]   cla_sum;
    logic         cla_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    cla4_nibble_sequencer #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .cla_a     (cla_a),
        .cla_b     (cla_b),
        .cla_cin   (cla_cin),
        .cla_sum   (cla_sum),
        .cla_cout  (cla_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // Behavioural 4-bit adder stage downstream of the sequencer.
    assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_cin};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // result is consumed, so a following call accepts on the very next edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input int hold);
        logic [31:0] full;
        logic [31:0] m;
        logic [31:0] carry_k;
        logic [W-1:0] exp_sum;
        logic exp_cout, exp_ovf;
        int lat;

        full     = 32'(a) + 32'(b) + 32'(cin);
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);

        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = (hold == 0);
        @(negedge clk);

        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (lat < NIB) begin
                m       = (32'd1 << (4 * lat)) - 32'd1;
                carry_k = ((32'(a) & m) + (32'(b) & m) + 32'(cin)) >> (4 * lat);
                chk("run_cla_a", 32'(cla_a), (32'(a) >> (4 * lat)) & 32'hF);
                chk("run_cla_b", 32'(cla_b), (32'(b) >> (4 * lat)) & 32'hF);
                chk("run_cla_cin", 32'(cla_cin), carry_k & 32'd1);
                chk("run_in_ready", 32'(in_ready), 32'd0);
            end
            // Operands may change after acceptance; stray in_valid must be ignored.
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(NIB));
        if (lat >= 20) begin
            in_valid = 1'b0;
            return;
        end

        for (int h = 0; h <= hold; h++) begin
            chk("done_valid", 32'(out_valid), 32'd1);
            chk("done_sum", 32'(out_sum), 32'(exp_sum));
            chk("done_cout", 32'(out_cout), 32'(exp_cout));
            chk("done_ovf", 32'(out_ovf), 32'(exp_ovf));
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_cla_a", 32'(cla_a), 32'd0);
            in_valid  = (h < hold);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            out_ready = (h == hold);
            if (h < hold) @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_sum_masked", 32'(out_sum), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cla", {23'd0, cla_a, cla_b, cla_cin}, 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 16'h0FFF, 1'b0, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 0);
        do_op(16'hC3A5, 16'h5A3C, 1'b1, 10);
        do_op(16'h0F0F, 16'hF0F1, 1'b0, 0);

        // Reset on the second RUN cycle discards the operation.
        in_valid = 1'b1;
        in_a = 16'hAAAA;
        in_b = 16'h5555;
        in_cin = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_cla", {23'd0, cla_a, cla_b, cla_cin}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        do_op(16'h0001, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
